id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch.
//  - Owns the IF/ID latch and the 32x32 architectural register file.
//  - Decodes the latched instruction, reads rs1/rs2, builds the ID/EX register.
//  - Detects load-use hazards and drives forward_stall back to fetch.
// PARAMETERS
//  RESET_ZERO_RF  1  1: register file cleared on rst; 0: only x0 guaranteed zero
// PORTS
//  clk           in   1                   clock
//  rst           in   1                   reset, synchronous, active-high
//  move          in   1                   global pipeline advance (0 while any memory port stalls)
//  flush         in   1                   EX redirect; kill IF/ID and ID/EX contents (tie 0 until branches land)
//  if_id_reg     in   if_id_stage_reg_t   fetch output: inst_s, pc_s, pc_next_s, order_s, valid_s
//  ex_valid      in   1                   EX-stage instruction valid
//  ex_is_load    in   1                   EX-stage instruction is a load
//  ex_rd_addr    in   5                   EX-stage destination register
//  wb_we         in   1                   WB write enable (already qualified by WB valid && move)
//  wb_rd_addr    in   5                   WB destination register
//  wb_rd_data    in   32                  WB write data
//  forward_stall out  1                   load-use hazard; fetch and IF/ID hold
//  id_ex_reg     out  id_ex_stage_reg_t   registered decode result for EX
// BEHAVIOUR
//  Reset:
//  - IF/ID latch valid=0, id_ex_reg fully zero (valid_s=0), forward_stall=0.
//  - RF cleared when RESET_ZERO_RF=1.
//  Posedge priority: rst > (move && flush) > (move && forward_stall) > move > hold.
//  - move=0: both latches hold. RF writes still occur.
//  - move && flush: IF/ID.valid<=0 and id_ex_reg.valid_s<=0. Data fields don't care.
//  - move && forward_stall: IF/ID holds; id_ex_reg<=bubble (valid_s=0, rd_we=0).
//  - move otherwise: IF/ID<=if_id_reg; id_ex_reg<=decode of current IF/ID.
//  Latency: one cycle IF/ID->ID/EX. Total two clock edges from fetch output to id_ex_reg.
//  Decode (combinational from IF/ID.inst):
//  - Fields: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
//  - Immediates sign-extended to 32 from inst[31]: I, S, B (bit0=0), U (low 12=0), J (bit0=0).
//  - uses_rs1: all opcodes except LUI/AUIPC/JAL. uses_rs2: STORE, BRANCH, OP only.
//  - rd_we=0 for STORE/BRANCH, and forced 0 when rd=0.
//  - Unknown opcode: valid passes through, illegal=1, rd_we=0, mem ops off.
//  Register file:
//  - x0 reads 0 always. Write at posedge when wb_we && wb_rd_addr!=0.
//  - Write-through: a same-cycle read of wb_rd_addr returns wb_rd_data.
//  - During a stall, ID re-reads every cycle, so a later WB value is captured.
//  forward_stall (combinational):
//    = IF/ID.valid && ex_valid && ex_is_load && ex_rd_addr!=0
//      && ((uses_rs1 && rs1==ex_rd_addr) || (uses_rs2 && rs2==ex_rd_addr))
//  - Held exactly one advancing cycle. The bubble enters EX, the load leaves, and the hazard clears.
//  - Flush the same cycle: flush wins and the stall result is discarded.
//  Non-load RAW hazards are resolved by EX/MEM forwarding, not here.
//  id_ex_reg fields: valid_s, pc_s, pc_next_s, order_s, inst_s, opcode, funct3, funct7,
//   rs1_addr, rs2_addr, rd_addr, rs1_v, rs2_v, imm, rd_we, mem_read, mem_write, illegal.
//  order_s and pc_s pass through unchanged; RVFI ordering relies on bubbles having valid_s=0.
// STRUCTURE
//  rv32i_types package:
//  - id_ex_stage_reg_t.
//  - Opcode constants (op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg).
//  - Immediate-format enum.
//  One sub-module: id_regfile (2 read ports, 1 write port, write-through, x0 hardwired).
//  Decode and hazard logic stay inline.
// TESTING
//  1. rst held 2 cycles, then released -> id_ex_reg.valid_s=0, forward_stall=0; rs1 read of x5 = 0.
//  2. WB writes x5=0xDEADBEEF; ADDI x6,x5,-1 (0xFFF28313) in the same cycle
//     -> rs1_v=0xDEADBEEF, imm=0xFFFFFFFF, rd_addr=6, rd_we=1.
//  3. EX holds LW x7 (ex_is_load=1, ex_rd_addr=7); ID holds ADD x8,x7,x1
//     -> forward_stall=1 for 1 cycle, bubble in ID/EX, ADD issued next cycle.
//  4. EX load to x0, ID reads x0 -> forward_stall=0. Write of x0=0x1234 -> x0 still reads 0.
//  5. move=0 for 3 cycles with new if_id_reg -> IF/ID and id_ex_reg unchanged; WB write to x9 still lands.
//  6. flush with move=1 while ID holds a valid inst -> next cycle id_ex_reg.valid_s=0; IF/ID valid=0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared RV32I types: opcode constants, immediate formats and the IF/ID and ID/EX stage registers.
// Also holds the immediate builder used by decode.
package rv32i_types;

  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] inst_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    logic        valid_s;
  } if_id_stage_reg_t;

  typedef struct packed {
    logic        valid_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    logic [31:0] inst_s;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] imm;
    logic        rd_we;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } id_ex_stage_reg_t;

  // The opcode bits never contribute to an immediate, so only inst[31:7] is taken.
  function automatic logic [31:0] build_imm(input logic [31:7] ib, input imm_fmt_e fmt);
    case (fmt)
      IMM_I:   return {{20{ib[31]}}, ib[31:20]};
      IMM_S:   return {{20{ib[31]}}, ib[31:25], ib[11:7]};
      IMM_B:   return {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
      IMM_U:   return {ib[31:12], 12'h000};
      IMM_J:   return {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Pipeline-side connections of the decode stage: fetch input, EX/WB feedback, stall and ID/EX output.
interface id_stage_if;
  import rv32i_types::*;

  logic              move;
  logic              flush;
  if_id_stage_reg_t  if_id_reg;
  logic              ex_valid;
  logic              ex_is_load;
  logic [4:0]        ex_rd_addr;
  logic              wb_we;
  logic [4:0]        wb_rd_addr;
  logic [31:0]       wb_rd_data;
  logic              forward_stall;
  id_ex_stage_reg_t  id_ex_reg;

  modport master (
    output move, flush, if_id_reg, ex_valid, ex_is_load, ex_rd_addr,
    output wb_we, wb_rd_addr, wb_rd_data,
    input  forward_stall, id_ex_reg
  );

  modport slave (
    input  move, flush, if_id_reg, ex_valid, ex_is_load, ex_rd_addr,
    input  wb_we, wb_rd_addr, wb_rd_data,
    output forward_stall, id_ex_reg
  );

endinterface

// File: rtl/id_stage_regfile.sv
// 32x32 architectural register file: two read ports, one write port, x0 hardwired to zero.
// Reads bypass the write port so a same-cycle WB value is visible to decode.
module id_regfile #(
  parameter bit RESET_ZERO_RF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_v,
  output logic [31:0] o_rs2_v,
  input  logic        i_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data
);

  logic [31:0] r_regs [32];
  logic        w_wr_en;

  assign w_wr_en = i_we && (i_rd_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst && RESET_ZERO_RF) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_rd_addr] <= i_rd_data;
    end
  end

  always_comb begin
    o_rs1_v = r_regs[i_rs1_addr];
    o_rs2_v = r_regs[i_rs2_addr];
    if (w_wr_en && (i_rd_addr == i_rs1_addr)) o_rs1_v = i_rd_data;
    if (w_wr_en && (i_rd_addr == i_rs2_addr)) o_rs2_v = i_rd_data;
    if (i_rs1_addr == 5'd0) o_rs1_v = '0;
    if (i_rs2_addr == 5'd0) o_rs2_v = '0;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID latch, register file read, decode, load-use hazard detection
// and the ID/EX register.
module id_stage
  import rv32i_types::*;
#(
  parameter bit RESET_ZERO_RF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  if_id_stage_reg_t r_if_id_p0;
  id_ex_stage_reg_t r_id_ex_p1;
  id_ex_stage_reg_t w_dec;
  imm_fmt_e         w_fmt;
  logic [31:0]      w_inst;
  logic [4:0]       w_rs1_addr;
  logic [4:0]       w_rs2_addr;
  logic [4:0]       w_rd_addr;
  logic [31:0]      w_rs1_v;
  logic [31:0]      w_rs2_v;
  logic             w_uses_rs1;
  logic             w_uses_rs2;
  logic             w_writes_rd;
  logic             w_stall;

  assign w_inst     = r_if_id_p0.inst_s;
  assign w_rs1_addr = w_inst[19:15];
  assign w_rs2_addr = w_inst[24:20];
  assign w_rd_addr  = w_inst[11:7];

  id_regfile #(
    .RESET_ZERO_RF (RESET_ZERO_RF)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_rs1_addr (w_rs1_addr),
    .i_rs2_addr (w_rs2_addr),
    .o_rs1_v    (w_rs1_v),
    .o_rs2_v    (w_rs2_v),
    .i_we       (bus.wb_we),
    .i_rd_addr  (bus.wb_rd_addr),
    .i_rd_data  (bus.wb_rd_data)
  );

  // Stage p0 -> decode (combinational from the IF/ID latch)
  always_comb begin
    w_fmt       = IMM_NONE;
    w_uses_rs1  = 1'b1;
    w_uses_rs2  = 1'b0;
    w_writes_rd = 1'b1;
    w_dec           = '0;
    w_dec.valid_s   = r_if_id_p0.valid_s;
    w_dec.pc_s      = r_if_id_p0.pc_s;
    w_dec.pc_next_s = r_if_id_p0.pc_next_s;
    w_dec.order_s   = r_if_id_p0.order_s;
    w_dec.inst_s    = w_inst;
    w_dec.opcode    = w_inst[6:0];
    w_dec.funct3    = w_inst[14:12];
    w_dec.funct7    = w_inst[31:25];
    w_dec.rs1_addr  = w_rs1_addr;
    w_dec.rs2_addr  = w_rs2_addr;
    w_dec.rd_addr   = w_rd_addr;
    w_dec.rs1_v     = w_rs1_v;
    w_dec.rs2_v     = w_rs2_v;
    case (w_inst[6:0])
      op_lui, op_auipc: begin
        w_fmt      = IMM_U;
        w_uses_rs1 = 1'b0;
      end
      op_jal: begin
        w_fmt      = IMM_J;
        w_uses_rs1 = 1'b0;
      end
      op_jalr, op_imm: w_fmt = IMM_I;
      op_load: begin
        w_fmt          = IMM_I;
        w_dec.mem_read = 1'b1;
      end
      op_store: begin
        w_fmt           = IMM_S;
        w_uses_rs2      = 1'b1;
        w_writes_rd     = 1'b0;
        w_dec.mem_write = 1'b1;
      end
      op_br: begin
        w_fmt       = IMM_B;
        w_uses_rs2  = 1'b1;
        w_writes_rd = 1'b0;
      end
      op_reg: w_uses_rs2 = 1'b1;
      default: begin
        w_writes_rd   = 1'b0;
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.imm   = build_imm(w_inst[31:7], w_fmt);
    w_dec.rd_we = w_writes_rd && (w_rd_addr != 5'd0);
  end

  // A load in EX cannot forward its result in time; hold the consumer one cycle.
  assign w_stall = r_if_id_p0.valid_s && bus.ex_valid && bus.ex_is_load
                   && (bus.ex_rd_addr != 5'd0)
                   && ((w_uses_rs1 && (w_rs1_addr == bus.ex_rd_addr))
                    || (w_uses_rs2 && (w_rs2_addr == bus.ex_rd_addr)));

  // Stage boundary p0 -> p1: IF/ID and ID/EX latches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_id_p0 <= '0;
      r_id_ex_p1 <= '0;
    end else if (bus.move) begin
      if (bus.flush) begin
        r_if_id_p0.valid_s <= 1'b0;
        r_id_ex_p1.valid_s <= 1'b0;
      end else if (w_stall) begin
        r_id_ex_p1 <= '0;
      end else begin
        r_if_id_p0 <= bus.if_id_reg;
        r_id_ex_p1 <= w_dec;
      end
    end
  end

  assign bus.forward_stall = w_stall;
  assign bus.id_ex_reg     = r_id_ex_p1;

endmodule

// File: tb/tb_id_stage.sv
// Directed plus randomized bench for id_stage against a behavioural model of the decode stage.
module tb_id_stage;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus();

  id_stage #(.RESET_ZERO_RF(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0]      m_rf [32];
  if_id_stage_reg_t m_ifid;
  id_ex_stage_reg_t m_idex;
  bit               m_bubble;
  bit               m_imm_known;
  logic [31:0]      f_pc = 32'h0000_1000;
  logic [63:0]      f_order = 64'd0;
  id_ex_stage_reg_t snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_uses1(input logic [31:0] in);
    return !(in[6:0] inside {op_lui, op_auipc, op_jal});
  endfunction

  function automatic bit ref_uses2(input logic [31:0] in);
    return in[6:0] inside {op_store, op_br, op_reg};
  endfunction

  function automatic bit ref_stall();
    logic [31:0] in;
    in = m_ifid.inst_s;
    if (!(m_ifid.valid_s && bus.ex_valid && bus.ex_is_load && bus.ex_rd_addr != 0)) return 1'b0;
    return (ref_uses1(in) && in[19:15] == bus.ex_rd_addr) || (ref_uses2(in) && in[24:20] == bus.ex_rd_addr);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.wb_we && bus.wb_rd_addr == a) return bus.wb_rd_data;
    return m_rf[a];
  endfunction

  // Immediates produced by sign-propagating arithmetic shifts of the scattered fields.
  task automatic ref_decode(input if_id_stage_reg_t f, output id_ex_stage_reg_t e, output bit known);
    logic [31:0] in;
    logic [31:0] t;
    bit we;
    in = f.inst_s;
    e = '0;
    e.valid_s = f.valid_s; e.pc_s = f.pc_s; e.pc_next_s = f.pc_next_s; e.order_s = f.order_s;
    e.inst_s = in; e.opcode = in[6:0]; e.funct3 = in[14:12]; e.funct7 = in[31:25];
    e.rs1_addr = in[19:15]; e.rs2_addr = in[24:20]; e.rd_addr = in[11:7];
    e.rs1_v = ref_read(in[19:15]); e.rs2_v = ref_read(in[24:20]);
    we = 1; known = 1;
    case (in[6:0])
      op_lui, op_auipc: e.imm = {in[31:12], 12'h0};
      op_jal: begin t = {in[31], in[19:12], in[20], in[30:21], 1'b0, 11'b0}; e.imm = $signed(t) >>> 11; end
      op_jalr, op_imm: e.imm = $signed(in) >>> 20;
      op_load: begin e.imm = $signed(in) >>> 20; e.mem_read = 1; end
      op_store: begin t = {in[31:25], in[11:7], 20'b0}; e.imm = $signed(t) >>> 20; e.mem_write = 1; we = 0; end
      op_br: begin t = {in[31], in[7], in[30:25], in[11:8], 1'b0, 19'b0}; e.imm = $signed(t) >>> 19; we = 0; end
      op_reg: known = 0;
      default: begin e.illegal = 1; we = 0; known = 0; end
    endcase
    e.rd_we = we && (in[11:7] != 0);
  endtask

  task automatic model_edge(input bit st);
    if (rst) begin
      m_ifid = '0; m_idex = '0; m_bubble = 1; m_imm_known = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      if (bus.move) begin
        if (bus.flush) begin
          m_ifid.valid_s = 0; m_idex.valid_s = 0; m_bubble = 0;
        end else if (st) begin
          m_idex = '0; m_bubble = 1;
        end else begin
          ref_decode(m_ifid, m_idex, m_imm_known);
          m_bubble = 0;
          m_ifid = bus.if_id_reg;
        end
      end
      if (bus.wb_we && bus.wb_rd_addr != 0) m_rf[bus.wb_rd_addr] = bus.wb_rd_data;
    end
  endtask

  task automatic check_idex();
    chk("id_ex.valid_s", bus.id_ex_reg.valid_s, m_idex.valid_s);
    if (m_bubble) chk("bubble.rd_we", bus.id_ex_reg.rd_we, 0);
    if (m_idex.valid_s) begin
      chk("pc_s", bus.id_ex_reg.pc_s, m_idex.pc_s);
      chk("pc_next_s", bus.id_ex_reg.pc_next_s, m_idex.pc_next_s);
      chk("order_s", bus.id_ex_reg.order_s, m_idex.order_s);
      chk("inst_s", bus.id_ex_reg.inst_s, m_idex.inst_s);
      chk("fields", {bus.id_ex_reg.opcode, bus.id_ex_reg.funct3, bus.id_ex_reg.funct7,
                     bus.id_ex_reg.rs1_addr, bus.id_ex_reg.rs2_addr, bus.id_ex_reg.rd_addr},
                    {m_idex.opcode, m_idex.funct3, m_idex.funct7,
                     m_idex.rs1_addr, m_idex.rs2_addr, m_idex.rd_addr});
      chk("rs1_v", bus.id_ex_reg.rs1_v, m_idex.rs1_v);
      chk("rs2_v", bus.id_ex_reg.rs2_v, m_idex.rs2_v);
      chk("ctl", {bus.id_ex_reg.rd_we, bus.id_ex_reg.mem_read, bus.id_ex_reg.mem_write, bus.id_ex_reg.illegal},
                 {m_idex.rd_we, m_idex.mem_read, m_idex.mem_write, m_idex.illegal});
      if (m_imm_known) chk("imm", bus.id_ex_reg.imm, m_idex.imm);
    end
  endtask

  // One clock: stall sampled at the falling edge, ID/EX sampled 1 time unit after the rising edge.
  task automatic tick();
    bit st;
    @(negedge clk);
    st = ref_stall();
    if (!rst) chk("forward_stall", bus.forward_stall, st);
    @(posedge clk);
    model_edge(st);
    #1;
    check_idex();
  endtask

  task automatic set_fetch(input logic [31:0] inst, input bit v);
    bus.if_id_reg.inst_s    = inst;
    bus.if_id_reg.pc_s      = f_pc;
    bus.if_id_reg.pc_next_s = f_pc + 32'd4;
    bus.if_id_reg.order_s   = f_order;
    bus.if_id_reg.valid_s   = v;
    f_pc    = f_pc + 32'd4;
    f_order = f_order + 64'd1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12];
    logic [31:0] r;
    logic [6:0]  op;
    ops = '{op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store, op_imm, op_reg,
            7'h0F, 7'h73, 7'h00};
    r  = $urandom();
    op = ops[$urandom_range(0, 11)];
    if (op == 7'h00) op = 7'($urandom());
    if ($urandom_range(0, 1) == 0)
      return {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), r[14:12],
              5'($urandom_range(0, 7)), op};
    return {r[31:7], op};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_ifid = '0; m_idex = '0; m_bubble = 1; m_imm_known = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    bus.move = 0; bus.flush = 0; bus.if_id_reg = '0;
    bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_rd_addr = 0;
    bus.wb_we = 0; bus.wb_rd_addr = 0; bus.wb_rd_data = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("t1_idex_zero", 64'(bus.id_ex_reg === '0), 64'd1);
    chk("t1_stall", bus.forward_stall, 0);

    bus.move = 1;
    set_fetch(32'h0002_8533, 1);            // ADD x10,x5,x0
    tick();
    set_fetch(32'hFFF2_8313, 1);            // ADDI x6,x5,-1
    tick();
    chk("t1_rs1_x5", bus.id_ex_reg.rs1_v, 32'h0);

    bus.wb_we = 1; bus.wb_rd_addr = 5; bus.wb_rd_data = 32'hDEAD_BEEF;
    set_fetch(32'h0000_0013, 1);
    tick();
    bus.wb_we = 0;
    chk("t2_rs1_v", bus.id_ex_reg.rs1_v, 32'hDEAD_BEEF);
    chk("t2_imm", bus.id_ex_reg.imm, 32'hFFFF_FFFF);
    chk("t2_rd", bus.id_ex_reg.rd_addr, 6);
    chk("t2_rd_we", bus.id_ex_reg.rd_we, 1);

    set_fetch(32'h0013_8433, 1);            // ADD x8,x7,x1
    tick();
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd_addr = 7;
    set_fetch(32'h0000_0013, 1);
    #1 chk("t3_stall_on", bus.forward_stall, 1);
    tick();
    chk("t3_bubble_valid", bus.id_ex_reg.valid_s, 0);
    chk("t3_bubble_rd_we", bus.id_ex_reg.rd_we, 0);
    bus.ex_valid = 0;
    #1 chk("t3_stall_off", bus.forward_stall, 0);
    tick();
    chk("t3_add_valid", bus.id_ex_reg.valid_s, 1);
    chk("t3_add_rd", bus.id_ex_reg.rd_addr, 8);

    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd_addr = 0;
    set_fetch(32'h0000_0133, 1);            // ADD x2,x0,x0
    tick();
    #1 chk("t4_stall_x0", bus.forward_stall, 0);
    bus.wb_we = 1; bus.wb_rd_addr = 0; bus.wb_rd_data = 32'h0000_1234;
    tick();
    bus.wb_we = 0;
    chk("t4_x0_same", {bus.id_ex_reg.rs1_v, bus.id_ex_reg.rs2_v}, 64'h0);
    tick();
    chk("t4_x0_after", bus.id_ex_reg.rs1_v, 32'h0);
    bus.ex_valid = 0;

    snap = bus.id_ex_reg;
    bus.move = 0;
    set_fetch(32'h0004_8533, 1);            // ADD x10,x9,x0
    bus.wb_we = 1; bus.wb_rd_addr = 9; bus.wb_rd_data = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.wb_we = 0;
      chk("t5_hold", 64'(bus.id_ex_reg === snap), 64'd1);
    end
    bus.move = 1;
    tick();
    chk("t5_ifid_held", bus.id_ex_reg.inst_s, 32'h0000_0133);
    tick();
    chk("t5_x9", bus.id_ex_reg.rs1_v, 32'hCAFE_F00D);

    bus.flush = 1;
    set_fetch(32'h0000_0013, 1);
    tick();
    bus.flush = 0;
    chk("t6_idex_killed", bus.id_ex_reg.valid_s, 0);
    set_fetch(32'h0010_0093, 1);
    tick();
    chk("t6_ifid_killed", bus.id_ex_reg.valid_s, 0);
    tick();
    chk("t6_resume", bus.id_ex_reg.valid_s, 1);

    for (int n = 0; n < 400; n++) begin
      bus.move       = ($urandom_range(0, 99) < 85);
      bus.flush      = ($urandom_range(0, 99) < 5);
      bus.ex_valid   = $urandom_range(0, 1);
      bus.ex_is_load = $urandom_range(0, 1);
      bus.ex_rd_addr = 5'($urandom_range(0, 7));
      bus.wb_we      = ($urandom_range(0, 99) < 40);
      bus.wb_rd_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom());
      bus.wb_rd_data = $urandom();
      set_fetch(rand_inst(), ($urandom_range(0, 9) != 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
